// File: rtl/snake_multi_engine_if.sv
// Bundles the game-engine I/O (frame/start/direction inputs, food position,
// pixel query and status outputs) between the SoC side and the engine.
interface snake_multi_engine_if #(
    parameter int NUM_SNAKES = 2,
    parameter int MAX_LEN    = 16,
    parameter int GRID_W     = 80,
    parameter int GRID_H     = 60
);
    localparam int CX = $clog2(GRID_W);
    localparam int CY = $clog2(GRID_H);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic                       frame_tick;
    logic                       start;
    logic [NUM_SNAKES-1:0]      dir_valid;
    logic [2*NUM_SNAKES-1:0]    dir_code;
    logic [CX-1:0]              food_x;
    logic [CY-1:0]              food_y;
    logic [9:0]                 DrawX;
    logic [9:0]                 DrawY;
    logic [NUM_SNAKES-1:0]      pix_body;
    logic [NUM_SNAKES-1:0]      pix_head;
    logic [NUM_SNAKES-1:0]      food_eaten;
    logic [NUM_SNAKES*LW-1:0]   length;
    logic [NUM_SNAKES-1:0]      alive;
    logic                       game_over;

    modport master (
        output frame_tick, start, dir_valid, dir_code, food_x, food_y, DrawX, DrawY,
        input  pix_body, pix_head, food_eaten, length, alive, game_over
    );

    modport slave (
        input  frame_tick, start, dir_valid, dir_code, food_x, food_y, DrawX, DrawY,
        output pix_body, pix_head, food_eaten, length, alive, game_over
    );
endinterface

// File: rtl/snake_multi_engine.sv
// N-player grid snake engine: segment shift buffers per snake, lock-step
// movement every MOVE_DIV frames, collision/food resolution, pixel hit query.
module snake_multi_engine #(
    parameter int NUM_SNAKES = 2,
    parameter int MAX_LEN    = 16,
    parameter int START_LEN  = 3,
    parameter int GRID_W     = 80,
    parameter int GRID_H     = 60,
    parameter int SEG_SHIFT  = 3,
    parameter int MOVE_DIV   = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    snake_multi_engine_if.slave bus
);
    localparam int CX = $clog2(GRID_W);
    localparam int CY = $clog2(GRID_H);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(MOVE_DIV + 3);
    localparam int CW = $clog2(NUM_SNAKES + 1);

    localparam logic [1:0] DIR_UP = 2'b00, DIR_DOWN = 2'b01, DIR_LEFT = 2'b10, DIR_RIGHT = 2'b11;
    localparam logic signed [CX:0] ONE_X = 1, ZERO_X = 0, LIM_X = GRID_W;
    localparam logic signed [CY:0] ONE_Y = 1, ZERO_Y = 0, LIM_Y = GRID_H;
    localparam logic [TW-1:0] DIV_T = TW'(MOVE_DIV);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_CALC, S_COMMIT, S_OVER} state_t;
    state_t state, state_nxt;

    logic [CX-1:0] seg_x [NUM_SNAKES][MAX_LEN];
    logic [CY-1:0] seg_y [NUM_SNAKES][MAX_LEN];
    logic [LW-1:0] len [NUM_SNAKES];
    logic [1:0]    cur_dir [NUM_SNAKES];
    logic [1:0]    pend_dir [NUM_SNAKES];
    logic [NUM_SNAKES-1:0] alive;
    logic [TW-1:0] tick_cnt, tick_sum;
    logic          tick_goal, restart, game_end;

    logic signed [CX:0] nx [NUM_SNAKES];
    logic signed [CY:0] ny [NUM_SNAKES];
    logic [NUM_SNAKES-1:0] off, will_eat, die_c, eat_c;
    logic [CX-1:0] nh_x_q [NUM_SNAKES];
    logic [CY-1:0] nh_y_q [NUM_SNAKES];
    logic [NUM_SNAKES-1:0] die_q, eat_q, food_eaten_q;
    logic [NUM_SNAKES-1:0] pb_c, ph_c, pb_q, ph_q;
    logic [CW-1:0] live_after;
    logic [9:0]    cell_x, cell_y;

    // Starting column of segment k of snake i: even snakes trail to the left, odd to the right.
    function automatic logic [CX-1:0] init_x(input int i, input int k);
        int hx;
        hx = (i + 1) * GRID_W / (NUM_SNAKES + 1);
        return CX'((i % 2 == 0) ? hx - k : hx + k);
    endfunction

    assign tick_sum  = tick_cnt + TW'(bus.frame_tick);
    assign tick_goal = (tick_sum >= DIV_T);
    assign restart   = (state == S_OVER) && bus.start;

    // Candidate next head, off-grid flag and food hit per snake.
    always_comb begin
        for (int i = 0; i < NUM_SNAKES; i++) begin
            nx[i] = {1'b0, seg_x[i][0]};
            ny[i] = {1'b0, seg_y[i][0]};
            case (pend_dir[i])
                DIR_UP:   ny[i] = ny[i] - ONE_Y;
                DIR_DOWN: ny[i] = ny[i] + ONE_Y;
                DIR_LEFT: nx[i] = nx[i] - ONE_X;
                default:  nx[i] = nx[i] + ONE_X;
            endcase
            off[i] = (nx[i] < ZERO_X) || (nx[i] >= LIM_X) || (ny[i] < ZERO_Y) || (ny[i] >= LIM_Y);
            will_eat[i] = !off[i] && (nx[i][CX-1:0] == bus.food_x) && (ny[i][CY-1:0] == bus.food_y);
        end
    end

    // Death resolution: walls, any live body (tail vacates unless its owner eats), head-to-head.
    always_comb begin
        die_c = '0;
        for (int i = 0; i < NUM_SNAKES; i++) begin
            if (alive[i]) begin
                if (off[i]) die_c[i] = 1'b1;
                for (int j = 0; j < NUM_SNAKES; j++) begin
                    for (int k = 0; k < MAX_LEN; k++) begin
                        if ((LW'(k) < len[j]) && (nx[i][CX-1:0] == seg_x[j][k]) &&
                            (ny[i][CY-1:0] == seg_y[j][k]) &&
                            !(alive[j] && (LW'(k) == len[j] - LW'(1)) && !will_eat[j]))
                            die_c[i] = 1'b1;
                    end
                    if ((j != i) && alive[j] && !off[i] && !off[j] && (nx[i] == nx[j]) && (ny[i] == ny[j]))
                        die_c[i] = 1'b1;
                end
            end
        end
        eat_c = alive & ~die_c & will_eat;
    end

    // Survivors remaining after the step being committed.
    always_comb begin
        live_after = '0;
        for (int i = 0; i < NUM_SNAKES; i++)
            live_after = live_after + CW'(alive[i] & ~die_q[i]);
        game_end = (NUM_SNAKES == 1) ? (live_after == '0) : (live_after <= CW'(1));
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start) state_nxt = S_RUN;
            S_RUN:    if (tick_goal) state_nxt = S_CALC;
            S_CALC:   state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = game_end ? S_OVER : S_RUN;
            S_OVER:   if (bus.start) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Game datapath: init/restart, direction latch, tick divider, calc capture, commit.
    always_ff @(posedge Clk) begin
        if (Reset || restart) begin
            for (int i = 0; i < NUM_SNAKES; i++) begin
                for (int k = 0; k < MAX_LEN; k++) begin
                    seg_x[i][k] <= init_x(i, k);
                    seg_y[i][k] <= CY'(GRID_H / 2);
                end
                len[i]      <= LW'(START_LEN);
                cur_dir[i]  <= (i % 2 == 0) ? DIR_RIGHT : DIR_LEFT;
                pend_dir[i] <= (i % 2 == 0) ? DIR_RIGHT : DIR_LEFT;
                nh_x_q[i]   <= '0;
                nh_y_q[i]   <= '0;
            end
            alive        <= '1;
            tick_cnt     <= '0;
            die_q        <= '0;
            eat_q        <= '0;
            food_eaten_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SNAKES; i++) begin
                if (state != S_OVER && bus.dir_valid[i] && ((bus.dir_code[2*i +: 2] ^ cur_dir[i]) != 2'b01))
                    pend_dir[i] <= bus.dir_code[2*i +: 2];
            end
            if (state == S_RUN)
                tick_cnt <= tick_goal ? '0 : tick_sum;
            else if (state == S_CALC || state == S_COMMIT)
                tick_cnt <= tick_sum;
            if (state == S_CALC) begin
                die_q <= die_c;
                eat_q <= eat_c;
                for (int i = 0; i < NUM_SNAKES; i++) begin
                    nh_x_q[i] <= nx[i][CX-1:0];
                    nh_y_q[i] <= ny[i][CY-1:0];
                end
            end
            food_eaten_q <= (state == S_COMMIT) ? eat_q : '0;
            if (state == S_COMMIT) begin
                for (int i = 0; i < NUM_SNAKES; i++) begin
                    if (alive[i] && !die_q[i]) begin
                        for (int k = MAX_LEN - 1; k > 0; k--) begin
                            seg_x[i][k] <= seg_x[i][k-1];
                            seg_y[i][k] <= seg_y[i][k-1];
                        end
                        seg_x[i][0] <= nh_x_q[i];
                        seg_y[i][0] <= nh_y_q[i];
                        cur_dir[i]  <= pend_dir[i];
                        if (eat_q[i] && len[i] != LW'(MAX_LEN)) len[i] <= len[i] + LW'(1);
                    end
                    if (die_q[i]) alive[i] <= 1'b0;
                end
            end
        end
    end

    assign cell_x = bus.DrawX >> SEG_SHIFT;
    assign cell_y = bus.DrawY >> SEG_SHIFT;

    // Pixel hit test against every live-length segment and each head.
    always_comb begin
        pb_c = '0;
        ph_c = '0;
        for (int i = 0; i < NUM_SNAKES; i++) begin
            for (int k = 0; k < MAX_LEN; k++)
                if ((LW'(k) < len[i]) && (cell_x == 10'(seg_x[i][k])) && (cell_y == 10'(seg_y[i][k])))
                    pb_c[i] = 1'b1;
            ph_c[i] = (cell_x == 10'(seg_x[i][0])) && (cell_y == 10'(seg_y[i][0]));
        end
    end

    // Registered pixel query result.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pb_q <= '0;
            ph_q <= '0;
        end else begin
            pb_q <= pb_c;
            ph_q <= ph_c;
        end
    end

    for (genvar g = 0; g < NUM_SNAKES; g++) begin : g_len
        assign bus.length[g*LW +: LW] = len[g];
    end

    assign bus.pix_body   = pb_q;
    assign bus.pix_head   = ph_q;
    assign bus.food_eaten = food_eaten_q;
    assign bus.alive      = alive;
    assign bus.game_over  = (state == S_OVER);
endmodule

// File: doc/snake_multi_engine.md
Name: snake_multi_engine

Overview:
Parametrised grid-based snake game engine for N players, the successor to the fixed two-snake, per-module movement scheme. It holds every snake's body in per-player segment shift buffers and steps all snakes together on a frame-tick divider. It latches directions, detects wall, body and head-to-head collisions, handles food growth, and answers per-pixel hit queries from the colour mapper. It sits between the keycode/SoC outputs and the VGA colour path.

Parameters:
NUM_SNAKES, 2, number of player channels (1..4)
MAX_LEN, 16, maximum segments per snake
START_LEN, 3, length after reset/restart (<= MAX_LEN)
GRID_W, 80, grid columns
GRID_H, 60, grid rows
SEG_SHIFT, 3, log2 of cell size in pixels (8 px cells)
MOVE_DIV, 4, frame ticks per movement step (>= 1)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous active-high reset
frame_tick  in  1  one-cycle pulse per video frame, already synchronised to Clk
start  in  1  one-cycle pulse: IDLE->RUN, OVER->IDLE
dir_valid  in  NUM_SNAKES  per-snake direction request strobe
dir_code  in  2*NUM_SNAKES  per-snake direction: 00 up, 01 down, 10 left, 11 right
food_x  in  CX=$clog2(GRID_W)  food column
food_y  in  CY=$clog2(GRID_H)  food row
DrawX  in  10  current pixel x
DrawY  in  10  current pixel y
pix_body  out  NUM_SNAKES  registered: pixel lies in a segment of snake i
pix_head  out  NUM_SNAKES  registered: pixel lies in the head cell of snake i
food_eaten  out  NUM_SNAKES  one-cycle pulse when snake i ate food
length  out  NUM_SNAKES*LW  per-snake length, LW=$clog2(MAX_LEN+1)
alive  out  NUM_SNAKES  per-snake alive flag
game_over  out  1  high in OVER state

Behaviour:
- FSM: IDLE, RUN, CALC, COMMIT, OVER. Reset (any state, any cycle) -> IDLE, with bodies re-initialised, length=START_LEN, alive all 1, tick counter 0, outputs pix_*/food_eaten/game_over 0.
- Initial body, snake i: head x=(i+1)*GRID_W/(NUM_SNAKES+1), y=GRID_H/2. Even i faces right, with segments trailing left (x-1, x-2, ...). Odd i faces left, with segments trailing right.
- IDLE: static, bodies drawn; start -> RUN.
- RUN: tick counter increments on each frame_tick. On the tick that brings the count to MOVE_DIV, the counter clears and the FSM goes to CALC. Ticks arriving in CALC/COMMIT are still counted.
- Direction: dir_valid[i] latches dir_code[i] into pending_dir[i] in any state except OVER. A request opposite to the current direction is discarded. The last request before CALC wins. The current direction updates in COMMIT.
- CALC (1 cycle): for each live snake compute next_head = head + pending_dir.
  - Dies: next_head off-grid (x<0, x>=GRID_W, y<0, y>=GRID_H, using signed width CX+1/CY+1).
  - Dies: next_head equals any segment k<length of any snake, dead snakes included. A live snake's tail segment is excluded unless that snake eats this step.
  - Dies: next_head equals another live snake's next_head (both die).
  - eat[i] = survives and next_head==(food_x,food_y).
- COMMIT (1 cycle): surviving snakes shift segments (seg[k]<=seg[k-1], seg[0]<=next_head).
  - On eat, length+1, saturating at MAX_LEN; food_eaten[i] still pulses at saturation.
  - Dead snakes freeze in place and remain obstacles; alive[i] clears.
  - Next state OVER if live count ==0 (NUM_SNAKES==1) or <=1 (NUM_SNAKES>1); else RUN.
- OVER: game_over=1, no movement; start -> IDLE with full re-initialisation.
- Pixel query: cell=(DrawX>>SEG_SHIFT, DrawY>>SEG_SHIFT). pix_body[i] = any k<length[i] matches; pix_head[i] = seg[0] matches. Both are registered, 1-cycle latency, valid in all states.
- Segments k>=length are don't-care and never match.
- start during RUN/CALC/COMMIT is ignored.

Test Plan:
- Reset then idle, NUM_SNAKES=2: length=3/3, alive=11, game_over=0. Snake0 head (26,30); snake1 head (53,30).
- start, 4 frame_ticks -> snake0 head (27,30), snake1 (52,30), 2 cycles after the 4th tick. No movement after 3 ticks.
- Snake0 dir_code=10 (reversal) then 00 before step -> moves up to (26,29). The reversal is discarded.
- Drive snake0 right to x=79, one more step -> alive[0]=0, game_over=1, snake0 frozen. start -> IDLE with initial bodies.
- food at (27,30), step -> food_eaten[0] pulses 1 cycle, length[0]=4. At length 16, eating pulses but length stays 16.
- Heads at (39,30)/(41,30) facing each other, step -> both die, no food_eaten. With DrawX=8*39, DrawY=240 over the frozen head, pix_head[0]=1 one cycle after presentation.
